speck_cmd_parser: RTL
=====================

# speck_cmd_parser

Byte-level command framer between `uart_rx` and the SPECK UART controller. Consumes the raw `rx_data`/`rx_valid` byte stream and assembles fixed-length command frames: opcode byte plus big-endian payload. Completed frames go to the controller on a valid/ready handshake. Malformed, truncated or overrun frames are reported on a one-cycle error strobe.

## Interface

Parameters:
- `W`, 32: SPECK word width; key payload is 4·W bits, block payload is 2·W bits.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle gap between payload bytes (10 ms at 100 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: asynchronous active-low reset.
- `rx_data` input 8: received byte from `uart_rx`.
- `rx_valid` input 1: single-cycle strobe qualifying `rx_data`.
- `cmd_valid` output 1: complete frame available.
- `cmd_ready` input 1: controller accepts the frame.
- `cmd_op` output 2: 0 = KEY, 1 = ENC, 2 = DEC.
- `cmd_key` output 4W: key payload, {K3,K2,K1,K0}; first received byte is the MSB.
- `cmd_blk` output 2W: block payload, {x,y}; first received byte is the MSB.
- `err_valid` output 1: one-cycle error strobe.
- `err_code` output 2: 1 = bad opcode, 2 = timeout, 3 = overrun; held until the next error.
- `busy` output 1: high in PAYLOAD or HOLD.

## Operation

- Opcodes: `K` (0x4B) takes 16 payload bytes; `E` (0x45) takes 8; `D` (0x44) takes 8.
- `R` (0x52) is consumed by the top-level reset logic and is silently ignored in IDLE. It is treated as ordinary data in PAYLOAD.
- States:
  - IDLE:
    - Valid opcode: latch `cmd_op`, clear the byte counter, go to PAYLOAD.
    - Other byte except `R`: raise `err_valid`, `err_code` = 1, stay in IDLE.
  - PAYLOAD:
    - Each `rx_valid` shifts the byte into a 128-bit shift register (left shift, new byte in bits [7:0]), increments the counter and reloads the timeout counter.
    - On the last byte, go to HOLD.
    - When the timeout expires: `err_code` = 2, discard the frame, go to IDLE.
  - HOLD:
    - `cmd_valid` = 1.
    - On `cmd_valid && cmd_ready`, go to IDLE.
    - `rx_valid` without a handshake in the same cycle: byte dropped, `err_code` = 3, stay in HOLD.
- Payload mapping: `cmd_key` = shift[127:0]; `cmd_blk` = shift[63:0]. For E/D frames only `cmd_blk` is meaningful; `cmd_key` content is unspecified.
- Payload outputs and `cmd_op` are stable from the `cmd_valid` rise through the handshake cycle.
- Simultaneous `rx_valid` and handshake in HOLD: the handshake completes and the byte is processed as an IDLE opcode in that same cycle. No overrun is flagged.
- Byte counter is 5 bits. Payload length is 16 or 8, selected by the latched opcode. There is no wrap case.
- Timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits. It counts only in PAYLOAD and saturates at expiry.

## Timing

- Reset values: `cmd_valid` 0, `cmd_op` 0, `cmd_key` 0, `cmd_blk` 0, `err_valid` 0, `err_code` 0, `busy` 0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. No error is reported.
- `cmd_valid` rises on the clock edge after the cycle carrying the final payload `rx_valid`.
- `cmd_valid` falls on the edge after the handshake cycle.
- `err_valid` is high exactly one cycle, on the edge after the offending event.
- Timeout fires when TIMEOUT_CYCLES consecutive PAYLOAD cycles pass with no `rx_valid`, counted from the cycle after the last accepted byte. State is IDLE on the following edge.
- Throughput: one byte per cycle is accepted in IDLE/PAYLOAD, so there is no back-pressure to `uart_rx`.

## Structure

- Shared package `speck_uart_pkg`:
  - opcode constants (`OP_KEY_CHAR`, `OP_ENC_CHAR`, `OP_DEC_CHAR`, `OP_RST_CHAR`);
  - `cmd_op` encodings;
  - `err_code` encodings;
  - payload length constants.
- One sub-module, `speck_timeout_ctr`: reloadable down-counter with enable and an expiry flag, parameterised by TIMEOUT_CYCLES. Reusable by the TX side.

## Test plan

- Send `E` then 01 23 45 67 89 AB CD EF with `cmd_ready` = 1 → one `cmd_valid` pulse, `cmd_op` = 1, `cmd_blk` = 0x0123456789ABCDEF.
- Send `K` then 1B1A1918 13121110 0B0A0908 03020100 with `cmd_ready` held low 20 cycles → `cmd_valid` stays high and stable, `cmd_key` = 0x1B1A1918131211100B0A090803020100, `cmd_op` = 0; released on ready.
- With TIMEOUT_CYCLES = 50, send `D` plus 3 bytes, then idle 60 cycles → `err_valid` pulse with `err_code` = 2, `busy` = 0, no `cmd_valid`.
- Byte 0x5A in IDLE → `err_code` = 1 pulse. Byte 0x52 in IDLE → no error, state stays IDLE.
- With a frame held in HOLD, send an extra byte → `err_code` = 3. Then send a byte in the same cycle as the handshake → no error, new frame starts.
- Assert `rst_n` low after 5 of 8 `E` payload bytes → all outputs return to reset values asynchronously. A following full `E` frame decodes correctly.

Source files
------------

// File: rtl/speck_uart_pkg.sv
// Shared constants and types for the SPECK UART command path.
// Opcode characters, command/error encodings and payload lengths (byte counts for W = 32).
package speck_uart_pkg;

  localparam logic [7:0] OP_KEY_CHAR = 8'h4B;
  localparam logic [7:0] OP_ENC_CHAR = 8'h45;
  localparam logic [7:0] OP_DEC_CHAR = 8'h44;
  localparam logic [7:0] OP_RST_CHAR = 8'h52;

  localparam logic [4:0] KEY_LEN = 5'd16;
  localparam logic [4:0] BLK_LEN = 5'd8;

  typedef enum logic [1:0] {
    CMD_KEY = 2'd0,
    CMD_ENC = 2'd1,
    CMD_DEC = 2'd2
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_OP  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HOLD    = 2'd2
  } parser_state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_KEY_CHAR) || (b == OP_ENC_CHAR) || (b == OP_DEC_CHAR);
  endfunction

  function automatic cmd_op_e decode_op(input logic [7:0] b);
    case (b)
      OP_KEY_CHAR: return CMD_KEY;
      OP_ENC_CHAR: return CMD_ENC;
      default:     return CMD_DEC;
    endcase
  endfunction

  function automatic logic [4:0] payload_len(input cmd_op_e op);
    return (op == CMD_KEY) ? KEY_LEN : BLK_LEN;
  endfunction

endpackage

// File: rtl/speck_cmd_parser_if.sv
// Byte stream in, framed command and error strobe out.
// slave = the parser; master = the uart_rx / controller side.
interface speck_cmd_parser_if #(parameter int W = 32);
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [4*W-1:0] cmd_key;
  logic [2*W-1:0] cmd_blk;
  logic           err_valid;
  logic [1:0]     err_code;
  logic           busy;

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_op, cmd_key, cmd_blk, err_valid, err_code, busy
  );

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_op, cmd_key, cmd_blk, err_valid, err_code, busy
  );
endinterface

// File: rtl/speck_timeout_ctr.sv
// Reloadable down-counter: expired is high once TIMEOUT_CYCLES enabled cycles follow a reload.
// Loads TIMEOUT_CYCLES-1 so expiry is visible during the final enabled cycle; saturates at zero.
module speck_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/speck_cmd_parser.sv
// Frames the uart_rx byte stream into opcode + big-endian payload commands.
// Frames wait in HOLD for cmd_ready; bytes arriving there without a handshake are dropped as overruns.
module speck_cmd_parser
  import speck_uart_pkg::*;
#(
  parameter int W              = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                clk,
  input logic                rst_n,
  speck_cmd_parser_if.slave  bus
);

  parser_state_e  state, state_d;
  cmd_op_e        op, op_d;
  logic [4*W-1:0] shift, shift_d;
  logic [4:0]     cnt, cnt_d;
  logic           err_valid, err_valid_d;
  err_code_e      err_code, err_code_d;
  logic           to_reload, to_en, to_expired;

  speck_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .reload  (to_reload),
    .en      (to_en),
    .expired (to_expired)
  );

  assign to_en = (state == ST_PAYLOAD) && !bus.rx_valid;

  always_comb begin
    state_d     = state;
    op_d        = op;
    shift_d     = shift;
    cnt_d       = cnt;
    err_valid_d = 1'b0;
    err_code_d  = err_code;
    to_reload   = 1'b0;
    case (state)
      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          shift_d   = {shift[4*W-9:0], bus.rx_data};
          cnt_d     = cnt + 5'd1;
          to_reload = 1'b1;
          if (cnt == payload_len(op) - 5'd1) begin
            state_d = ST_HOLD;
          end
        end else if (to_expired) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        // HOLD with a handshake behaves like IDLE for a byte arriving in the same cycle.
        if ((state == ST_HOLD) && !bus.cmd_ready) begin
          if (bus.rx_valid) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
          end
        end else begin
          state_d = ST_IDLE;
          if (bus.rx_valid) begin
            if (is_opcode(bus.rx_data)) begin
              op_d      = decode_op(bus.rx_data);
              cnt_d     = 5'd0;
              to_reload = 1'b1;
              state_d   = ST_PAYLOAD;
            end else if (bus.rx_data != OP_RST_CHAR) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_BAD_OP;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op        <= CMD_KEY;
      shift     <= '0;
      cnt       <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_d;
      op        <= op_d;
      shift     <= shift_d;
      cnt       <= cnt_d;
      err_valid <= err_valid_d;
      err_code  <= err_code_d;
    end
  end

  assign bus.cmd_valid = (state == ST_HOLD);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cmd_op    = op;
  assign bus.cmd_key   = shift;
  assign bus.cmd_blk   = shift[2*W-1:0];
  assign bus.err_valid = err_valid;
  assign bus.err_code  = err_code;

endmodule
